// File: rtl/data_mem_unit.sv
// data_mem_unit: multi-cycle data memory with valid/ready request and response handshakes.
// Define BYTE_EN_EN to add the req_be port and byte-lane masked stores/swaps.
module data_mem_unit #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int DEPTH         = 128,
  parameter int LATENCY       = 2,
  parameter int INIT_IDENTITY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
`ifdef BYTE_EN_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int MI_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (INIT_IDENTITY != 0) ? DATA_W'(i) : '0;
    end
    return m;
  endfunction

  // The array has no reset on purpose: contents survive rst.
  mem_t mem_q = init_mem();

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic [BYTES-1:0]    in_be;
  logic                in_idle;
  logic [1:0]          cur_op;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   cur_idx;
  logic [DATA_W-1:0]   cur_wdata;
  logic [BYTES-1:0]    cur_be;
  logic [MI_W-1:0]     mem_idx;
  logic                cur_err;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   wr_word;
  logic                commit;
  logic                mem_we;

`ifdef BYTE_EN_EN
  assign in_be = req_be;
`else
  assign in_be = '1;
`endif

  // With LATENCY=0 the commit happens on the accept edge, so decode the live request in IDLE.
  assign in_idle   = (state_q == IDLE);
  assign cur_op    = in_idle ? req_op    : op_q;
  assign cur_addr  = in_idle ? req_addr  : addr_q;
  assign cur_wdata = in_idle ? req_wdata : wdata_q;
  assign cur_be    = in_idle ? in_be     : be_q;
  assign cur_idx   = cur_addr >> OFF_W;
  assign mem_idx   = cur_idx[MI_W-1:0];
  assign cur_err   = (cur_op == 2'b11)
                   || ((cur_addr & ADDR_W'(BYTES - 1)) != '0)
                   || (cur_idx >= ADDR_W'(DEPTH));
  assign old_word  = mem_q[mem_idx];

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign wr_word[gi*8 +: 8] = cur_be[gi] ? cur_wdata[gi*8 +: 8] : old_word[gi*8 +: 8];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          op_d        = req_op;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = in_be;
          cnt_d       = CNT_W'(LATENCY);
          req_ready_d = 1'b0;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      resp_valid_d = 1'b1;
      resp_err_d   = cur_err;
      resp_rdata_d = (cur_err || cur_op == OP_STORE) ? '0 : old_word;
    end
  end

  assign mem_we = commit && !cur_err && (cur_op == OP_STORE || cur_op == OP_SWAP);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= OP_LOAD;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed bench for data_mem_unit, one instance with LATENCY=2 and one with LATENCY=0.
module tb_data_mem_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = 4'hF;
  logic        resp_ready = 1'b1;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ready_a, ready_b, rv_a, rv_b, err_a, err_b;
  logic [31:0] rd_a, rd_b;
  bit          sel = 1'b0;

  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef BYTE_EN_EN
    .req_be(req_be),
`endif
    .resp_valid(rv_a), .resp_ready(resp_ready), .resp_rdata(rd_a), .resp_err(err_a));

  data_mem_unit #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef BYTE_EN_EN
    .req_be(req_be),
`endif
    .resp_valid(rv_b), .resp_ready(resp_ready), .resp_rdata(rd_b), .resp_err(err_b));

  assign cur_ready = sel ? ready_b : ready_a;
  assign cur_valid = sel ? rv_b    : rv_a;
  assign cur_rdata = sel ? rd_b    : rd_a;
  assign cur_err   = sel ? err_b   : err_a;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) valid_b = v;
    else     valid_a = v;
  endtask

  // Wait for req_ready, present one request, and drive it to its accept edge.
  task automatic present_req(input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("ready_wait", {31'd0, cur_ready}, 32'd1);
    req_op = op; req_addr = addr; req_wdata = wdata; req_be = be;
    set_valid(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(1'b0);
  endtask

  // Full transaction; lat counts accept edge to the edge where resp_valid is first seen high.
  task automatic run_req(input bit s, input string name, input logic [1:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input int hold, output logic [31:0] rd, output logic er, output int lat);
    bit ready_seen = 1'b0;
    bit stable = 1'b1;
    logic [31:0] d0;
    logic e0;
    sel = s;
    resp_ready = (hold == 0);
    present_req(op, addr, wdata, be);
    lat = 1;
    while (!cur_valid && lat < 20) begin
      if (cur_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    check_val({name, "_resp_timeout"}, {31'd0, cur_valid}, 32'd1);
    if (cur_ready) ready_seen = 1'b1;
    d0 = cur_rdata;
    e0 = cur_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!cur_valid || cur_rdata !== d0 || cur_err !== e0) stable = 1'b0;
      if (cur_ready) ready_seen = 1'b1;
    end
    if (hold > 0) check_val({name, "_held_stable"}, {31'd0, stable}, 32'd1);
    check_val({name, "_ready_low"}, {31'd0, ready_seen}, 32'd0);
    rd = cur_rdata;
    er = cur_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val({name, "_valid_drop"}, {31'd0, cur_valid}, 32'd0);
    $display("%s dut%0d op=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
             name, s, op, addr, wdata, be, rd, er, lat);
  endtask

  task automatic expect_req(input bit s, input string name, input logic [1:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic er;
    int lat;
    run_req(s, name, op, addr, wdata, be, 0, rd, er, lat);
    check_val({name, "_rdata"}, rd, exp_rd);
    check_val({name, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;

    repeat (2) @(negedge clk);
    check_val("rst_ready_a", {31'd0, ready_a}, 32'd0);
    check_val("rst_valid_a", {31'd0, rv_a}, 32'd0);
    check_val("rst_rdata_a", rd_a, 32'd0);
    check_val("rst_err_a", {31'd0, err_a}, 32'd0);
    check_val("rst_ready_b", {31'd0, ready_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", {31'd0, ready_a}, 32'd1);

    run_req(1'b0, "load10", 2'b00, 32'h10, 32'h0, 4'hF, 0, rd, er, lat);
    check_val("load10_lat", lat, 32'd3);
    check_val("load10_rdata", rd, 32'd4);
    check_val("load10_err", {31'd0, er}, 32'd0);

    run_req(1'b0, "store20", 2'b01, 32'h20, 32'hDEADBEEF, 4'hF, 4, rd, er, lat);
    check_val("store20_rdata", rd, 32'd0);
    check_val("store20_err", {31'd0, er}, 32'd0);
    expect_req(1'b0, "load20", 2'b00, 32'h20, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

    expect_req(1'b0, "swap08", 2'b10, 32'h08, 32'h000000AA, 4'hF, 32'd2, 1'b0);
    expect_req(1'b0, "load08", 2'b00, 32'h08, 32'h0, 4'hF, 32'hAA, 1'b0);

    expect_req(1'b0, "load06_mis", 2'b00, 32'h06, 32'h0, 4'hF, 32'd0, 1'b1);
    expect_req(1'b0, "load200_oor", 2'b00, 32'h200, 32'h0, 4'hF, 32'd0, 1'b1);
    expect_req(1'b0, "op11", 2'b11, 32'h04, 32'h1234, 4'hF, 32'd0, 1'b1);
    expect_req(1'b0, "store06_mis", 2'b01, 32'h06, 32'h5678, 4'hF, 32'd0, 1'b1);
    expect_req(1'b0, "load04", 2'b00, 32'h04, 32'h0, 4'hF, 32'd1, 1'b0);

    // Reset while the LATENCY=2 store sits in WAIT: no write may land.
    sel = 1'b0;
    present_req(2'b01, 32'h0C, 32'h55, 4'hF);
    rst = 1'b1;
    #1;
    check_val("midrst_ready", {31'd0, ready_a}, 32'd0);
    check_val("midrst_valid", {31'd0, rv_a}, 32'd0);
    check_val("midrst_err", {31'd0, err_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("midrst dut0 store 0C discarded by reset");
    expect_req(1'b0, "load0C_after_rst", 2'b00, 32'h0C, 32'h0, 4'hF, 32'd3, 1'b0);

    run_req(1'b1, "l0_load10", 2'b00, 32'h10, 32'h0, 4'hF, 0, rd, er, lat);
    check_val("l0_load10_lat", lat, 32'd1);
    check_val("l0_load10_rdata", rd, 32'd4);

    // LATENCY=0: the store commits on the accept edge, so reset only drops the response.
    sel = 1'b1;
    present_req(2'b01, 32'h0C, 32'h55, 4'hF);
    check_val("l0_store_valid", {31'd0, rv_b}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("l0_midrst_valid", {31'd0, rv_b}, 32'd0);
    check_val("l0_midrst_rdata", rd_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("l0_midrst dut1 store 0C committed, response dropped");
    expect_req(1'b1, "l0_load0C", 2'b00, 32'h0C, 32'h0, 4'hF, 32'h55, 1'b0);
    expect_req(1'b0, "load0C_l2_untouched", 2'b00, 32'h0C, 32'h0, 4'hF, 32'd3, 1'b0);

`ifdef BYTE_EN_EN
    expect_req(1'b0, "be_load30", 2'b00, 32'h30, 32'h0, 4'h0, 32'h0000000C, 1'b0);
    expect_req(1'b0, "be_store30", 2'b01, 32'h30, 32'hFFFFFFFF, 4'b0101, 32'd0, 1'b0);
    expect_req(1'b0, "be_load30b", 2'b00, 32'h30, 32'h0, 4'h0, 32'h00FF00FF, 1'b0);
    expect_req(1'b0, "be_swap30", 2'b10, 32'h30, 32'h11223344, 4'b1000, 32'h00FF00FF, 1'b0);
    expect_req(1'b0, "be_load30c", 2'b00, 32'h30, 32'h0, 4'h0, 32'h11FF00FF, 1'b0);
    expect_req(1'b0, "be_store_none", 2'b01, 32'h30, 32'hABCDEF01, 4'b0000, 32'd0, 1'b0);
    expect_req(1'b0, "be_load30d", 2'b00, 32'h30, 32'h0, 4'h0, 32'h11FF00FF, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle data memory in the processor's memory stage.
- Accepts one load, store or atomic swap request at a time over a valid/ready handshake.
- Models a configurable access latency and returns read data and an error flag over a second valid/ready handshake.
- Lets the core stall on memory, which the previous single-cycle array could not do.

Parameters:
- DATA_W, 32, data word width in bits (multiple of 8).
- ADDR_W, 32, byte-address width.
- DEPTH, 128, number of DATA_W words in the array.
- LATENCY, 2, wait cycles between request acceptance and access commit (0 allowed).
- INIT_IDENTITY, 1, if 1 word i is initialised to value i at time zero, else to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  2  00 load, 01 store, 10 swap (read old, write new), 11 illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store/swap data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  load data or old word for swap; 0 for store/error.
- resp_err  out  1  request was illegal, misaligned or out of range.

Behaviour:
- Reset values: req_ready=0 while rst is high, then 1 in IDLE. resp_valid=0, resp_rdata=0, resp_err=0, state IDLE, wait counter 0.
- Memory array is not cleared by reset; contents persist across reset.
- Word index = req_addr[ADDR_W-1:log2(DATA_W/8)].
- Misaligned means any low byte-offset bit is nonzero.
- Out of range means index >= DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture op, addr and wdata, and load the counter with LATENCY.
  - Go to WAIT if LATENCY>0; otherwise commit on this same edge and go to RESP.
- WAIT:
  - req_ready=0 and the counter decrements each cycle.
  - On the edge where the counter reaches 1, commit and go to RESP.
  - resp_valid rises exactly LATENCY+1 cycles after the accept edge.
- Commit:
  - load: resp_rdata = mem[idx].
  - store: mem[idx] <= wdata; resp_rdata = 0.
  - swap: resp_rdata = old mem[idx] and mem[idx] <= wdata on the same edge.
  - Error (op 11, misaligned or out of range): no array write, resp_rdata=0, resp_err=1.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_valid&&resp_ready.
  - On that edge go to IDLE and clear resp_valid and resp_err.
  - req_ready stays 0 in RESP, so there is no request/response overlap.
  - At most one outstanding request.
- Request inputs are ignored outside IDLE; only captured values are used.
- Reset mid-operation: a request in WAIT that has not committed is discarded with no array write. A response in RESP is dropped. An already-committed write remains.
- Back-to-back: after the response handshake the unit is in IDLE next cycle. Maximum throughput is one request per LATENCY+2 cycles with resp_ready tied high.

Optional Feature:
- Macro BYTE_EN_EN.
- Defined:
  - Adds port req_be, input, DATA_W/8 bits, captured with the request.
  - Store and swap write only the byte lanes whose enable bit is 1; the other lanes keep their old value.
  - A swap still returns the full old word.
  - req_be=0 on a store is a legal no-op with resp_err=0.
  - Loads ignore req_be.
- Undefined: port absent; every store/swap writes the full word.

Test Plan:
- Reset then load addr 0x10 with LATENCY=2, INIT_IDENTITY=1 -> resp_valid rises 3 cycles after accept; resp_rdata=4, resp_err=0; req_ready=0 until response accepted.
- Store 0xDEADBEEF to 0x20, then load 0x20 -> store response rdata=0, err=0; load returns 0xDEADBEEF. Hold resp_ready=0 for 4 cycles -> resp_valid and data held stable.
- Swap 0x0000_00AA to 0x08 -> resp_rdata=2 (old word); subsequent load 0x08 returns 0xAA.
- Load 0x06 (misaligned), load 0x200 (index 128, out of range) and op 11 -> each gives resp_err=1, rdata=0, and the array is unchanged.
- Store 0x55 to 0x0C, assert rst during the WAIT cycle -> outputs go to reset values immediately; later load 0x0C returns 3. Repeat with LATENCY=0 -> response on the cycle after accept.
- With BYTE_EN_EN defined: word 0x30 holds 12 (0x0000000C); store 0xFFFFFFFF with req_be=4'b0101 -> load returns 0x00FF00FF.
